// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
//   state   | meaning
//   S_IDLE  | ready for a request, decode and latch on acceptance
//   S_READ  | fetch the addressed word into r_rdata
//   S_WRITE | one-cycle write of the full or merged word
//   S_RESP  | one-cycle completion pulse with error/load data
module load_store_unit #(
  parameter int MEM_AW      = 8,
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  logic        r_we;
  logic        r_err;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_range_err;
  logic        w_err;
  logic [4:0]  w_sh;
  logic [15:0] w_lane;
  logic [31:0] w_merge;
  logic [31:0] w_load;

  always_comb begin
    if (req_we) w_f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else        w_f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

  assign w_misalign  = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign w_range_err = RANGE_CHECK && (req_addr[31:MEM_AW+2] != '0);
  assign w_err       = !w_f3_ok || w_misalign || w_range_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_err    <= w_err;
            if (w_err)                                   r_state <= S_RESP;
            else if (req_we && req_funct3[1:0] == 2'b10) r_state <= S_WRITE;
            else                                         r_state <= S_READ;
          end
        end
        S_READ: begin
          r_rdata <= mem_rd_data;
          r_state <= r_we ? S_WRITE : S_RESP;
        end
        S_WRITE: r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane position comes from the latched address; misaligned cases never reach here.
  assign w_sh   = {r_addr[1:0], 3'b000};
  assign w_lane = 16'(r_rdata >> w_sh);

  always_comb begin
    w_merge = r_rdata;
    case (r_funct3[1:0])
      2'b00: w_merge[w_sh +: 8] = r_wdata[7:0];
      2'b01: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  always_comb begin
    case (r_funct3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane};
      3'b100:  w_load = {24'b0, w_lane[7:0]};
      3'b101:  w_load = {16'b0, w_lane};
      default: w_load = r_rdata;
    endcase
  end

  assign req_ready   = rst_n && (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_err    = resp_valid && r_err;
  assign resp_rdata  = (resp_valid && !r_err && !r_we) ? w_load : '0;
  assign mem_wr_en   = (r_state == S_WRITE);
  assign mem_addr    = {2'b00, r_addr[31:2]};
  assign mem_wr_data = mem_wr_en ? w_merge : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random requests against a
// word-array reference of the memory and the unit's access rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_AW(8), .RANGE_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  assign mem_rd_data = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (pre_we)         mem[pre_addr] <= pre_data;
    else if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wr_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic scramble_req();
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Issue one request and observe it to completion (sampling at negedges).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic err,
                       output logic [31:0] rd, output int nwr, output int wr_cyc,
                       output logic [31:0] wr_data, output logic [31:0] wr_addr);
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    scramble_req();
    lat = 0; err = 1'b0; rd = '0; nwr = 0; wr_cyc = 0; wr_data = '0; wr_addr = '0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_wr_en) begin
        nwr++; wr_cyc = c; wr_data = mem_wr_data; wr_addr = mem_addr;
      end
      if (resp_valid) begin
        lat = c; err = resp_err; rd = resp_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reference: expected outcome computed from the access rules and ref_mem.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit has_const, input logic [31:0] cval);
    logic        e_err;
    logic [31:0] e_rd, e_word, word, mask, field;
    int          e_lat, e_wrcyc, sh, size;
    bit          valid_f3;
    int          lat, nwr, wr_cyc;
    logic        err;
    logic [31:0] rd, wr_data, wr_addr;

    size = int'(f3[1:0]);
    if (we) valid_f3 = (f3 <= 3'd2);
    else    valid_f3 = (f3 <= 3'd2) || f3 == 3'd4 || f3 == 3'd5;
    e_err = !valid_f3 || (size == 1 && a[0]) || (size == 2 && a[1:0] != 2'b00) ||
            (a[31:10] != 22'd0);
    word   = ref_mem[a[9:2]];
    e_rd   = '0;
    e_word = word;
    sh     = 8 * int'(a[1:0]);
    mask   = (size == 0) ? 32'h0000_00FF : (size == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      e_lat = 2;
      field = (word >> sh) & mask;
      if (size == 0 && !f3[2] && field[7])  field = field | 32'hFFFF_FF00;
      if (size == 1 && !f3[2] && field[15]) field = field | 32'hFFFF_0000;
      e_rd = field;
    end else begin
      e_lat  = (size == 2) ? 2 : 3;
      e_word = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end
    e_wrcyc = e_lat - 1;

    issue(we, f3, a, wd, lat, err, rd, nwr, wr_cyc, wr_data, wr_addr);

    check_eq({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check_eq({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
    check_eq({tag, "_rdata"}, rd, e_rd);
    check_eq({tag, "_nwr"}, 32'(nwr), (we && !e_err) ? 32'd1 : 32'd0);
    if (we && !e_err) begin
      check_eq({tag, "_wrcyc"}, 32'(wr_cyc), 32'(e_wrcyc));
      check_eq({tag, "_wrdata"}, wr_data, e_word);
      check_eq({tag, "_wraddr"}, wr_addr, {2'b00, a[31:2]});
      ref_mem[a[9:2]] = e_word;
    end
    if (has_const) check_eq({tag, "_const"}, we ? wr_data : rd, cval);
  endtask

  logic [2:0] ld_ops [5];

  initial begin
    int          nwr, nresp, nready, nacc, pend, r1, r2, idle;
    logic [31:0] rd1, sw_wd, v;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;

    ld_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst_n = 1'b0; req_valid = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    scramble_req();

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      v = (i == 16) ? 32'h8899_AABB : $urandom;
      pre_we = 1'b1; pre_addr = 8'(i); pre_data = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_wr_data", mem_wr_data, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("ready_after_init", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    run_txn("lb",   1'b0, 3'd0, 32'h41, 32'h0, 1'b1, 32'hFFFF_FFAA);
    run_txn("lbu",  1'b0, 3'd4, 32'h41, 32'h0, 1'b1, 32'h0000_00AA);
    run_txn("lh",   1'b0, 3'd1, 32'h42, 32'h0, 1'b1, 32'hFFFF_8899);
    run_txn("lhu",  1'b0, 3'd5, 32'h40, 32'h0, 1'b1, 32'h0000_AABB);
    run_txn("lw",   1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 32'h8899_AABB);
    run_txn("sb",   1'b1, 3'd0, 32'h43, 32'h1234_5677, 1'b1, 32'h7799_AABB);
    run_txn("lw2",  1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 32'h7799_AABB);
    run_txn("sh_mis", 1'b1, 3'd1, 32'h41, 32'hCAFE, 1'b0, 32'h0);
    run_txn("ld011",  1'b0, 3'd3, 32'h40, 32'h0, 1'b0, 32'h0);
    run_txn("lw_oor", 1'b0, 3'd2, 32'h400, 32'h0, 1'b0, 32'h0);
    run_txn("sw_top", 1'b1, 3'd2, 32'h3FC, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    check_eq("word10_after", mem[16], 32'h7799_AABB);

    // Reset while the sub-word store is in its read cycle.
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h48; req_wdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    nwr = 0; nresp = 0; nready = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (mem_wr_en) nwr++;
      if (resp_valid) nresp++;
      if (req_ready) nready++;
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    check_eq("abort_wr", 32'(nwr), 32'd0);
    check_eq("abort_resp", 32'(nresp), 32'd0);
    check_eq("abort_ready_in_rst", 32'(nready), 32'd0);
    check_eq("abort_ready_after", {31'd0, req_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      if (mem_wr_en) nwr++;
      if (resp_valid) nresp++;
      @(negedge clk);
    end
    check_eq("abort_wr_late", 32'(nwr), 32'd0);
    check_eq("abort_resp_late", 32'(nresp), 32'd0);

    // Back-to-back LW then SW with req_valid held.
    sw_wd = $urandom;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = $urandom;
    nacc = 0; pend = 0; r1 = -1; r2 = -1; idle = 0; rd1 = '0;
    for (int c = 0; c < 16; c++) begin
      if (pend == 1) begin req_we = 1'b1; req_addr = 32'h80; req_wdata = sw_wd; end
      if (pend == 2) begin req_valid = 1'b0; scramble_req(); end
      pend = 0;
      if (resp_valid) begin
        if (r1 < 0) begin r1 = c; rd1 = resp_rdata; end
        else if (r2 < 0) r2 = c;
      end
      if (r1 >= 0 && r2 < 0 && req_ready) idle++;
      if (req_ready && req_valid) begin nacc++; pend = nacc; end
      @(negedge clk);
    end
    check_eq("b2b_accepts", 32'(nacc), 32'd2);
    check_eq("b2b_first_lat", 32'(r1), 32'd2);
    check_eq("b2b_spacing", 32'(r2 - r1), 32'd3);
    check_eq("b2b_idle", 32'(idle), 32'd1);
    check_eq("b2b_lw_data", rd1, ref_mem[16]);
    ref_mem[32] = sw_wd;

    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ld_ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else                            a = 32'($urandom_range(0, 1023));
      run_txn("rnd", we, f3, a, $urandom, 1'b0, 32'h0);
    end

    @(negedge clk);
    for (int i = 0; i < 256; i++) check_eq("mem_final", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit between the core's execute stage and the word-addressed data memory.
- Accepts one byte, halfword or word request at a time and checks alignment and address range.
- Stores: sub-word stores become read-modify-write word accesses; full-word stores are written directly.
- Loads: returns the selected byte/halfword/word, sign- or zero-extended.

Parameters:
- MEM_AW, 8, word-index width of the data memory (2**MEM_AW words).
- RANGE_CHECK, 1, when 1, a byte address with addr[31:MEM_AW+2] != 0 is an error.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 (size/sign)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  misaligned/illegal/out-of-range, valid with resp_valid
- resp_rdata  output  32  extended load data, valid with resp_valid
- mem_wr_en  output  1  data memory write enable
- mem_addr  output  32  word index to memory = {2'b0, addr_q[31:2]}
- mem_wr_data  output  32  word to write
- mem_rd_data  input  32  memory read data (combinational from mem_addr)

Behaviour:
- Handshake:
  - req_ready = 1 only in IDLE; 0 while rst_n = 0.
  - A request is accepted at a posedge with req_valid & req_ready.
  - addr_q, funct3_q, we_q and wdata_q latch at acceptance; later changes on req_* are ignored.
- States: IDLE, READ, WRITE, RESP.
- Reset: synchronous; rst_n = 0 at a posedge forces IDLE and clears rdata_q, err_q and the latched request.
- Reset values: resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_wr_en = 0, mem_addr = 0, mem_wr_data = 0.
- Outputs are decoded from state and registers only; no combinational path from req_* to mem_*.
- Decode at acceptance:
  - Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store funct3: 000 SB, 001 SH, 010 SW.
  - Any other funct3 → error.
  - Halfword with addr[0] = 1 → error.
  - Word with addr[1:0] != 0 → error.
  - RANGE_CHECK = 1 and upper address bits nonzero → error.
- Transitions from IDLE on acceptance:
  - error → RESP with err_q = 1
  - load, SB or SH → READ
  - SW → WRITE
- READ (one cycle):
  - mem_addr driven and mem_rd_data captured into rdata_q.
  - Load → RESP; SB/SH → WRITE.
- WRITE (exactly one cycle): mem_wr_en = 1, mem_addr = word index.
  - SW: mem_wr_data = wdata_q.
  - SB: rdata_q with byte lane addr_q[1:0] replaced by wdata_q[7:0].
  - SH: rdata_q with halfword lane addr_q[1] replaced by wdata_q[15:0].
  - Next state: RESP.
- RESP (one cycle): resp_valid = 1, then IDLE.
  - Load: resp_rdata = extracted lane, sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW.
  - Store or error: resp_rdata = 0.
- Latency, counted in cycles after acceptance with resp_valid high in the last one:
  - error 1
  - load 2
  - SW 2
  - SB/SH 3
- Back-to-back: a new request may be accepted in the IDLE cycle following RESP. Minimum spacing is one idle cycle; there is no bypass.
- Errors never assert mem_wr_en.
- Reset during READ or WRITE aborts the operation:
  - No write occurs after the reset edge.
  - No resp_valid is produced for the aborted request.
- mem_wr_en is never high for more than one consecutive cycle per request.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LB addr 0x41 → resp_rdata 0xFFFFFFAA; LBU 0x41 → 0x000000AA. resp_valid 2 cycles after accept, resp_err = 0.
- LH addr 0x42 → 0xFFFF8899; LHU 0x40 → 0x0000AABB; LW 0x40 → 0x8899AABB.
- SB addr 0x43, wdata 0x12345677 → one mem_wr_en pulse in cycle 2 with mem_wr_data 0x7799AABB. resp_valid in cycle 3; subsequent LW 0x40 → 0x7799AABB.
- SH addr 0x41 → resp_err = 1 in cycle 1, mem_wr_en never asserted, word unchanged. funct3 = 011 load → resp_err = 1.
- RANGE_CHECK = 1, LW addr 0x00000400 → resp_err = 1. SW addr 0x3FC, wdata 0xDEADBEEF → word 0xFF written in cycle 1, resp in cycle 2.
- SB accepted, rst_n = 0 during READ → no mem_wr_en, no resp_valid, req_ready = 0 during reset and 1 in the cycle after rst_n rises. Back-to-back LW, SW with req_valid held → two completions with exactly one idle cycle between them.
